score_display_ctrl: RTL and testbench

- Sequencer for the 4-digit seven-segment decoder (`display7`).
- Accepts a binary score (0..9999) on a load strobe and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits by driving `seg_number`/`an_number` into the decoder at a fixed refresh rate.
- Sits between game/score logic and `display7` at top level.

---
 rtl/score_display_ctrl.sv | 124 ++++++++++++
 tb/tb_score_display_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Converts a 0..9999 score to BCD with a 14-step shift-add-3 engine and scans four digits into display7.
// Conversion takes 15 busy cycles after load; load is dropped (not queued) while busy.
module score_display_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] value,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic [3:0]  seg_number,
   output logic [1:0]  an_number
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [13:0]      MAX_SCORE = 14'd9999;

   state_t           state;
   logic [13:0]      operand;
   logic [15:0]      scratch;
   logic [3:0]       bit_cnt;
   logic [15:0]      shown;
   logic [CNT_W-1:0] prescale;
   logic [14:0]      adj;

   // The thousands nibble never exceeds 9, so its MSB after adjust is always
   // shifted out; only the low 15 adjusted bits are kept.
   function automatic logic [14:0] add3(input logic [15:0] s);
      logic [14:0] r;
      logic [3:0]  n;
      for (int i = 0; i < 3; i++) begin
         n = s[4*i +: 4];
         if (n >= 4'd5) begin
            n = n + 4'd3;
         end
         r[4*i +: 4] = n;
      end
      n = s[15:12];
      if (n >= 4'd5) begin
         n = n + 4'd3;
      end
      r[14:12] = n[2:0];
      return r;
   endfunction

   assign adj = add3(scratch);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         operand <= '0;
         scratch <= '0;
         bit_cnt <= '0;
         shown   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  operand <= (value > MAX_SCORE) ? MAX_SCORE : value;
                  scratch <= '0;
                  bit_cnt <= 4'd13;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= {adj, operand[13]};
               operand <= {operand[12:0], 1'b0};
               if (bit_cnt == 4'd0) begin
                  done  <= 1'b1;
                  state <= COMMIT;
               end else begin
                  bit_cnt <= bit_cnt - 4'd1;
               end
            end
            COMMIT: begin
               shown <= scratch;
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Scan runs free of the converter so refresh never stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale  <= '0;
         an_number <= 2'd0;
      end else if (prescale == SCAN_LAST) begin
         prescale  <= '0;
         an_number <= an_number + 2'd1;
      end else begin
         prescale  <= prescale + 1'b1;
      end
   end

   always_comb begin
      seg_number = shown[15:12];
      case (an_number)
         2'd0:    seg_number = shown[15:12];
         2'd1:    seg_number = shown[11:8];
         2'd2:    seg_number = shown[7:4];
         default: seg_number = shown[3:0];
      endcase
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl with a fast scan rate; expected digits are queued at load time.
module tb_score_display_ctrl;

   localparam int RD = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        load  = 1'b0;
   logic [13:0] value = '0;
   logic        busy;
   logic        done;
   logic [3:0]  seg_number;
   logic [1:0]  an_number;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [15:0] exp_q[$];

   score_display_ctrl #(.REFRESH_DIV(RD), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .load       (load),
      .busy       (busy),
      .done       (done),
      .seg_number (seg_number),
      .an_number  (an_number)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] bcd_of(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   task automatic check_display(input string name);
      logic [15:0] got;
      logic [15:0] want;
      logic        bad_code;
      int          idx;
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL %s: scoreboard empty, nothing to compare", name);
         return;
      end
      want     = exp_q.pop_front();
      got      = 16'hFFFF;
      bad_code = 1'b0;
      for (int i = 0; i < 4 * RD; i++) begin
         idx = 3 - int'(an_number);
         got[4*idx +: 4] = seg_number;
         if (seg_number > 4'd9) bad_code = 1'b1;
         tick();
      end
      if (got !== want || bad_code) begin
         tests_failed++;
         $display("FAIL %s display: got %h (bad_code=%b), want %h", name, got, bad_code, want);
      end
   endtask

   task automatic run_load(input logic [13:0] v, input int ign_a, input int ign_b, input string name);
      int   dn;
      logic eb, ed;
      exp_q.push_back(bcd_of(int'(v)));
      value = v;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      dn    = 0;
      for (int i = 1; i <= 16; i++) begin
         eb = (i <= 15);
         ed = (i == 15);
         tests_run++;
         if (busy !== eb || done !== ed) begin
            tests_failed++;
            $display("FAIL %s timing k+%0d: busy=%b done=%b, want busy=%b done=%b",
                     name, i, busy, done, eb, ed);
         end
         if (done === 1'b1) dn++;
         if (i == ign_a || i == ign_b) begin
            value = 14'd500;
            load  = 1'b1;
         end
         tick();
         load = 1'b0;
      end
      tests_run++;
      if (dn != 1) begin
         tests_failed++;
         $display("FAIL %s done_count: got %0d, want 1", name, dn);
      end
      check_display(name);
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, an_number, seg_number} !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_state: busy=%b done=%b an=%0d seg=%0d, want all 0",
                  busy, done, an_number, seg_number);
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_idle_scan();
      logic [1:0] want_an;
      for (int n = 0; n <= 40; n++) begin
         want_an = 2'((n / RD) % 4);
         tests_run++;
         if (an_number !== want_an || seg_number !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_scan n=%0d: an=%0d seg=%0d busy=%b done=%b, want an=%0d seg=0 busy=0 done=0",
                     n, an_number, seg_number, busy, done, want_an);
         end
         tick();
      end
   endtask

   task automatic test_values();
      run_load(14'd1234, 0, 0, "load_1234");
      run_load(14'd9999, 0, 0, "load_9999");
      run_load(14'd10000, 0, 0, "load_10000");
      run_load(14'd16383, 0, 0, "load_16383");
      run_load(14'd0, 0, 0, "load_0");
      run_load(14'd7, 0, 0, "load_7");
   endtask

   task automatic test_ignored_load();
      run_load(14'd42, 3, 10, "ignore_while_busy");
   endtask

   task automatic test_reset_mid();
      value = 14'd5678;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      repeat (6) tick();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid pre: busy=%b, want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, an_number, seg_number} !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_mid async: busy=%b done=%b an=%0d seg=%0d, want all 0",
                  busy, done, an_number, seg_number);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back(16'h0000);
      check_display("reset_mid_blank");
      run_load(14'd5678, 0, 0, "reload_5678");
   endtask

   task automatic test_back_to_back();
      logic       eb, ed, pend;
      logic [15:0] want;
      int         dn;
      int         idx;
      repeat (3) exp_q.push_back(bcd_of(321));
      value = 14'd321;
      load  = 1'b1;
      tick();
      pend = 1'b0;
      dn   = 0;
      for (int i = 1; i <= 48; i++) begin
         eb = (i % 16) != 0;
         ed = (i % 16) == 15;
         tests_run++;
         if (busy !== eb || done !== ed) begin
            tests_failed++;
            $display("FAIL hold timing k+%0d: busy=%b done=%b, want busy=%b done=%b",
                     i, busy, done, eb, ed);
         end
         if (pend) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL hold commit k+%0d: scoreboard empty", i);
            end else begin
               want = exp_q.pop_front();
               idx  = 3 - int'(an_number);
               if (seg_number !== want[4*idx +: 4]) begin
                  tests_failed++;
                  $display("FAIL hold commit k+%0d: seg=%0d at an=%0d, want %0d",
                           i, seg_number, an_number, want[4*idx +: 4]);
               end
            end
         end
         pend = (done === 1'b1);
         if (done === 1'b1) dn++;
         if (i == 40) load = 1'b0;
         tick();
      end
      load = 1'b0;
      tests_run++;
      if (dn != 3) begin
         tests_failed++;
         $display("FAIL hold done_count: got %0d, want 3", dn);
      end
      exp_q.push_back(bcd_of(321));
      check_display("hold_321");
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_values();
      test_ignored_load();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
